regfile_write_arbiter: RTL and testbench

- Shares the single write path of an NREG x WIDTH general-purpose register bank between two requesters: requester 0 is the CPU datapath writeback and requester 1 is the debug/switch loader.
- It accepts req/ack write transactions and selects a winner with round-robin priority.
- For the winner it drives a one-hot Load vector and a common data bus into the bank's register instances (Clk/Reset/Load/in).
- One write completes every 2 cycles at most.

---
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 77 +++++++
 tb/tb_regfile_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two requesters and the
// register-bank write arbiter.
interface regfile_write_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
);
  logic             req0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             ack0;
  logic             req1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic             ack1;
  logic [NREG-1:0]  load;
  logic [WIDTH-1:0] reg_in;
  logic             busy;
  logic             last_grant;

  modport master (
    output req0, addr0, data0,
    output req1, addr1, data1,
    input  ack0, ack1, load,
    input  reg_in, busy, last_grant
  );

  modport slave (
    input  req0, addr0, data0,
    input  req1, addr1, data1,
    output ack0, ack1, load,
    output reg_in, busy, last_grant
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write
// port between CPU writeback (0) and debug loader (1).
module regfile_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input logic Clk,
  input logic Reset,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]       state;
  logic             ack0_q;
  logic             ack1_q;
  logic [NREG-1:0]  load_q;
  logic [WIDTH-1:0] reg_in_q;
  logic             busy_q;
  logic             last_q;

  logic             gnt0;
  logic             gnt1;
  logic [AW-1:0]    win_addr;
  logic [NREG-1:0]  dec;

  // On a tie the requester that did not win last time goes.
  always_comb begin
    gnt1 = bus.req1 & (~bus.req0 | ~last_q);
    gnt0 = bus.req0 & ~gnt1;
  end

  always_comb begin
    win_addr = gnt1 ? bus.addr1 : bus.addr0;
    dec = '0;
    dec[win_addr] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      load_q   <= '0;
      reg_in_q <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state  <= IDLE;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      load_q <= '0;
      busy_q <= 1'b0;
      // Requests are ignored in WRITE so a held req
      // at the ack edge is not granted twice.
      if (state == IDLE && (gnt0 || gnt1)) begin
        state    <= WRITE;
        ack0_q   <= gnt0;
        ack1_q   <= gnt1;
        load_q   <= dec;
        busy_q   <= 1'b1;
        reg_in_q <= gnt1 ? bus.data1 : bus.data0;
        last_q   <= gnt1;
      end
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.load       = load_q;
  assign bus.reg_in     = reg_in_q;
  assign bus.busy       = busy_q;
  assign bus.last_grant = last_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a
// behavioural grant model and a model register bank.
module tb_regfile_write_arbiter;
  localparam int W = 16;
  localparam int N = 8;
  localparam int A = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  regfile_write_arbiter_if #(
    .WIDTH(W), .NREG(N), .AW(A)
  ) bus ();

  regfile_write_arbiter #(
    .WIDTH(W), .NREG(N), .AW(A)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         who;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int lg = 1;
  bit m_idle = 1'b1;
  logic [W-1:0] bank [N];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model bank driven by the arbiter outputs.
  always @(posedge Clk) begin
    for (int i = 0; i < N; i++) begin
      if (Reset) bank[i] <= '0;
      else if (bus.load[i]) bank[i] <= bus.reg_in;
    end
  end

  // Reference: one grant per idle sample, then one write cycle.
  always @(posedge Clk) begin
    exp_t e;
    int w;
    if (Reset) begin
      m_idle = 1'b1;
      lg = 1;
    end else if (m_idle) begin
      w = -1;
      if (bus.req0 && bus.req1) w = (lg == 1) ? 0 : 1;
      else if (bus.req0) w = 0;
      else if (bus.req1) w = 1;
      if (w >= 0) begin
        e.who  = w;
        e.addr = (w == 0) ? bus.addr0 : bus.addr1;
        e.data = (w == 0) ? bus.data0 : bus.data1;
        q.push_back(e);
        lg = w;
        m_idle = 1'b0;
      end
    end else begin
      m_idle = 1'b1;
    end
  end

  // Monitor: any write activity must match the queue head.
  always @(negedge Clk) begin
    exp_t e;
    logic [N-1:0] oh;
    chk("both_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
    if (bus.busy || bus.ack0 || bus.ack1 || bus.load != 0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious: load=%h ack0=%b ack1=%b want idle",
                 bus.load, bus.ack0, bus.ack1);
      end else begin
        e = q.pop_front();
        oh = '0;
        oh[e.addr] = 1'b1;
        chk("load", 32'(bus.load), 32'(oh));
        chk("reg_in", 32'(bus.reg_in), 32'(e.data));
        chk("ack0", 32'(bus.ack0), 32'(e.who == 0));
        chk("ack1", 32'(bus.ack1), 32'(e.who == 1));
        chk("busy", 32'(bus.busy), 32'd1);
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing: no write, want ack%0d addr %0d",
               e.who, e.addr);
    end
    chk("last_grant", 32'(bus.last_grant), 32'(lg));
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_ack(input int i);
    int n;
    n = 0;
    while (1) begin
      @(negedge Clk);
      if ((i == 0 && bus.ack0) || (i == 1 && bus.ack1)) break;
      n++;
      if (n >= 10) begin
        checks++;
        errors++;
        $display("FAIL timeout: ack%0d got none want pulse", i);
        break;
      end
    end
  endtask

  initial begin
    int k;
    int last_t;
    int act;
    int who;
    bit r [2];

    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.data0 = '0;
    bus.data1 = '0;
    do_reset();

    // Reset state
    chk("rst_load", 32'(bus.load), 32'd0);
    chk("rst_reg_in", 32'(bus.reg_in), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_last", 32'(bus.last_grant), 32'd1);

    // Single write from requester 0
    bus.req0 = 1'b1;
    bus.addr0 = 3'd3;
    bus.data0 = 16'hBEEF;
    @(negedge Clk);
    chk("t1_load", 32'(bus.load), 32'h08);
    chk("t1_data", 32'(bus.reg_in), 32'hBEEF);
    chk("t1_ack0", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0;
    @(negedge Clk);
    chk("t1_load_off", 32'(bus.load), 32'd0);
    chk("t1_ack_off", 32'(bus.ack0), 32'd0);
    chk("t1_bank3", 32'(bank[3]), 32'hBEEF);

    // Tie after reset: requester 0 first
    do_reset();
    bus.req0 = 1'b1;
    bus.addr0 = 3'd1;
    bus.data0 = 16'h1111;
    bus.req1 = 1'b1;
    bus.addr1 = 3'd6;
    bus.data1 = 16'h6666;
    wait_ack(0);
    chk("t2_load0", 32'(bus.load), 32'h02);
    bus.req0 = 1'b0;
    wait_ack(1);
    chk("t2_load1", 32'(bus.load), 32'h40);
    bus.req1 = 1'b0;
    @(negedge Clk);
    chk("t2_last", 32'(bus.last_grant), 32'd1);

    // Both hold continuously: strict alternation every 2 cycles
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    k = 0;
    last_t = 0;
    for (int t = 0; t < 40 && k < 8; t++) begin
      @(negedge Clk);
      if (bus.ack0 || bus.ack1) begin
        who = bus.ack1 ? 1 : 0;
        chk("alt_who", 32'(who), 32'(k % 2));
        if (k > 0) chk("alt_gap", 32'(t - last_t), 32'd2);
        last_t = t;
        k++;
        if (who == 0) begin
          bus.addr0 = A'($urandom_range(0, N - 1));
          bus.data0 = W'($urandom);
        end else begin
          bus.addr1 = A'($urandom_range(0, N - 1));
          bus.data1 = W'($urandom);
        end
      end
    end
    chk("alt_count", 32'(k), 32'd8);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);

    // Data change after the sampling edge is ignored
    bus.req0 = 1'b1;
    bus.addr0 = 3'd2;
    bus.data0 = 16'h00AA;
    @(posedge Clk);
    #1 bus.data0 = 16'h5555;
    @(negedge Clk);
    chk("t4_data", 32'(bus.reg_in), 32'h00AA);
    bus.req0 = 1'b0;
    @(negedge Clk);
    chk("t4_bank2", 32'(bank[2]), 32'h00AA);

    // Reset in the WRITE cycle drops the write
    bus.req1 = 1'b1;
    bus.addr1 = 3'd7;
    bus.data1 = 16'hC3C3;
    wait_ack(1);
    Reset = 1'b1;
    bus.req1 = 1'b0;
    @(negedge Clk);
    chk("t5_load", 32'(bus.load), 32'd0);
    chk("t5_ack1", 32'(bus.ack1), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_reg_in", 32'(bus.reg_in), 32'd0);
    chk("t5_last", 32'(bus.last_grant), 32'd1);
    chk("t5_bank7", 32'(bank[7]), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // A req pulse between edges is never seen
    bus.req1 = 1'b1;
    #2 bus.req1 = 1'b0;
    act = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge Clk);
      if (bus.load != 0 || bus.ack1) act++;
    end
    chk("t6_quiet", 32'(act), 32'd0);

    // Random traffic obeying the handshake
    r[0] = 1'b0;
    r[1] = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        bit a;
        bit nw;
        a = (i == 0) ? bus.ack0 : bus.ack1;
        nw = 1'b0;
        if (r[i] && a) begin
          if ($urandom_range(0, 3) != 0) nw = 1'b1;
          else r[i] = 1'b0;
        end else if (!r[i] && $urandom_range(0, 2) == 0) begin
          r[i] = 1'b1;
          nw = 1'b1;
        end
        if (nw && i == 0) begin
          bus.addr0 = A'($urandom_range(0, N - 1));
          bus.data0 = W'($urandom);
        end
        if (nw && i == 1) begin
          bus.addr1 = A'($urandom_range(0, N - 1));
          bus.data1 = W'($urandom);
        end
      end
      bus.req0 = r[0];
      bus.req1 = r[1];
    end
    // Let any in-flight grant finish before dropping requests
    while (!m_idle || bus.busy) @(negedge Clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) @(negedge Clk);
    chk("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
